// File: rtl/fib_zeck_pkg.sv
// Shared types and constant functions for the Zeckendorf encoder.
// fib() follows F(1)=F(2)=1; min_code_w() gives the fewest digits that cover DATA_W bits.
package fib_zeck_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic logic [63:0] fib(input int n);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        a = 64'd1;
        b = 64'd1;
        for (int i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return (n <= 0) ? 64'd0 : b;
    endfunction

    // Smallest c with F(c+2) > 2^data_w - 1.
    function automatic int min_code_w(input int data_w);
        logic [63:0] max_val;
        int          c;
        max_val = (64'd1 << data_w) - 64'd1;
        c = 1;
        while ((fib(c + 2) <= max_val) && (c < 90)) begin
            c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/fib_weight_gen.sv
// Fibonacci weight pair stepping downward: load gives (F(CODE_W+1), F(CODE_W)), step maps (a,b)->(b,a-b).
// One step per clock, no stall input; the owner decides when to load or step.
module fib_weight_gen
    import fib_zeck_pkg::*;
#(
    parameter int W      = 17,
    parameter int CODE_W = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    output logic [W-1:0] fa_o
);

    localparam logic [W-1:0] FA_INIT = W'(fib(CODE_W + 1));
    localparam logic [W-1:0] FB_INIT = W'(fib(CODE_W));

    logic [W-1:0] fa_q, fa_d;
    logic [W-1:0] fb_q, fb_d;

    always_comb begin
        fa_d = fa_q;
        fb_d = fb_q;
        if (load_i) begin
            fa_d = FA_INIT;
            fb_d = FB_INIT;
        end else if (step_i) begin
            fa_d = fb_q;
            fb_d = fa_q - fb_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fa_q <= '0;
            fb_q <= '0;
        end else begin
            fa_q <= fa_d;
            fb_q <= fb_d;
        end
    end

    assign fa_o = fa_q;

endmodule

// File: rtl/fib_zeck_encoder_param.sv
// Greedy Zeckendorf encoder, one digit per clock; done_trans arrives CODE_W clocks after capture.
// Level request en_encode, no retrigger while held (HOLD); FIB_ZECK_OBFUS_EN adds an XOR key port.
module fib_zeck_encoder_param
    import fib_zeck_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CODE_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_encode,
    input  logic [DATA_W-1:0] input_binary,
`ifdef FIB_ZECK_OBFUS_EN
    input  logic [CODE_W-1:0] obfus_key,
`endif
    output logic              done_input,
    output logic              receive,
    output logic              done_trans,
    output logic [CODE_W-1:0] out_B
);

    localparam int RW    = DATA_W + 1;
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    if (CODE_W < min_code_w(DATA_W)) begin : g_code_w_too_small
        $error("CODE_W=%0d cannot represent every %0d-bit value", CODE_W, DATA_W);
    end

    state_e            state_q, state_d;
    logic [RW-1:0]     resid_q, resid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CODE_W-1:0] out_q, out_d;
    logic              done_input_q, done_input_d;
    logic              receive_q, receive_d;
    logic              done_trans_q, done_trans_d;
`ifdef FIB_ZECK_OBFUS_EN
    logic [CODE_W-1:0] key_q, key_d;
`endif

    logic              wg_load;
    logic              wg_step;
    logic [RW-1:0]     wg_fa;
    logic              digit;

    fib_weight_gen #(
        .W      (RW),
        .CODE_W (CODE_W)
    ) u_weight_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (wg_load),
        .step_i (wg_step),
        .fa_o   (wg_fa)
    );

    always_comb begin
        state_d      = state_q;
        resid_d      = resid_q;
        code_d       = code_q;
        idx_d        = idx_q;
        out_d        = out_q;
        done_input_d = 1'b0;
        receive_d    = receive_q;
        done_trans_d = 1'b0;
        wg_load      = 1'b0;
        wg_step      = 1'b0;
        digit        = 1'b0;
`ifdef FIB_ZECK_OBFUS_EN
        key_d        = key_q;
`endif
        case (state_q)
            IDLE: begin
                if (en_encode) begin
                    resid_d      = {1'b0, input_binary};
                    code_d       = '0;
                    idx_d        = IDX_W'(CODE_W - 1);
                    wg_load      = 1'b1;
                    done_input_d = 1'b1;
                    receive_d    = 1'b1;
`ifdef FIB_ZECK_OBFUS_EN
                    key_d        = obfus_key;
`endif
                    state_d      = CALC;
                end
            end
            CALC: begin
                digit         = (resid_q >= wg_fa);
                code_d[idx_q] = digit;
                if (digit) begin
                    resid_d = resid_q - wg_fa;
                end
                wg_step = 1'b1;
                idx_d   = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
`ifdef FIB_ZECK_OBFUS_EN
                    out_d = code_d ^ key_q;
`else
                    out_d = code_d;
`endif
                    done_trans_d = 1'b1;
                    receive_d    = 1'b0;
                    state_d      = en_encode ? HOLD : IDLE;
                end
            end
            HOLD: begin
                // Request still held from the finished encode: wait for release.
                if (!en_encode) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            resid_q      <= '0;
            code_q       <= '0;
            idx_q        <= '0;
            out_q        <= '0;
            done_input_q <= 1'b0;
            receive_q    <= 1'b0;
            done_trans_q <= 1'b0;
`ifdef FIB_ZECK_OBFUS_EN
            key_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            resid_q      <= resid_d;
            code_q       <= code_d;
            idx_q        <= idx_d;
            out_q        <= out_d;
            done_input_q <= done_input_d;
            receive_q    <= receive_d;
            done_trans_q <= done_trans_d;
`ifdef FIB_ZECK_OBFUS_EN
            key_q        <= key_d;
`endif
        end
    end

    assign done_input = done_input_q;
    assign receive    = receive_q;
    assign done_trans = done_trans_q;
    assign out_B      = out_q;

endmodule

// File: tb/tb_fib_zeck_encoder_param.sv
// Directed bench for fib_zeck_encoder_param at DATA_W=16, CODE_W=23 (define FIB_ZECK_OBFUS_EN for the key build).
module tb_fib_zeck_encoder_param;

    logic        clk;
    logic        rst;
    logic        en_encode;
    logic [15:0] input_binary;
`ifdef FIB_ZECK_OBFUS_EN
    logic [22:0] obfus_key;
`endif
    logic        done_input;
    logic        receive;
    logic        done_trans;
    logic [22:0] out_B;

    int n_vec = 0;
    int n_bad = 0;

    fib_zeck_encoder_param #(
        .DATA_W (16),
        .CODE_W (23)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_encode    (en_encode),
        .input_binary (input_binary),
`ifdef FIB_ZECK_OBFUS_EN
        .obfus_key    (obfus_key),
`endif
        .done_input   (done_input),
        .receive      (receive),
        .done_trans   (done_trans),
        .out_B        (out_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request: en_encode high for `hold` edges from capture; input (and key) scrambled after capture.
    // rehit toggles en_encode during CALC. Window of 50 cycles; lat is edges from capture to done_trans.
    task automatic run_encode(input logic [15:0] val, input logic [22:0] key, input int hold,
                              input bit rehit, output logic [22:0] code, output int lat,
                              output int n_di, output int n_dt, output logic rcv1,
                              output logic rcv_end);
        code = '0; lat = -1; n_di = 0; n_dt = 0; rcv1 = 1'b0; rcv_end = 1'b1;
        @(negedge clk);
        input_binary = val;
`ifdef FIB_ZECK_OBFUS_EN
        obfus_key = key;
`else
        if (key != '0) $display("note: key ignored without FIB_ZECK_OBFUS_EN");
`endif
        en_encode = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done_input) n_di++;
            if (done_trans) begin
                n_dt++;
                if (lat < 0) begin
                    lat  = k - 1;
                    code = out_B;
                end
            end
            if (k == 1)  rcv1 = receive;
            if (k == 24) rcv_end = receive;
            if (k == 2) begin
                input_binary = ~val;
`ifdef FIB_ZECK_OBFUS_EN
                obfus_key = ~key;
`endif
            end
            if (k == hold) en_encode = 1'b0;
            if (rehit) begin
                if (k == 5)  en_encode = 1'b1;
                if (k == 8)  en_encode = 1'b0;
                if (k == 12) en_encode = 1'b1;
            end
        end
        en_encode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [22:0] code;
    int          lat, n_di, n_dt;
    logic        rcv1, rcv_end;

    initial begin
        rst = 1'b0;
        en_encode = 1'b0;
        input_binary = '0;
`ifdef FIB_ZECK_OBFUS_EN
        obfus_key = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_out_B", 32'(out_B), 32'h0);
        chk("rst_done_input", 32'(done_input), 32'h0);
        chk("rst_receive", 32'(receive), 32'h0);
        chk("rst_done_trans", 32'(done_trans), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_receive", 32'(receive), 32'h0);
        chk("idle_out_B", 32'(out_B), 32'h0);
        chk("idle_done_trans", 32'(done_trans), 32'h0);

        // Encode 11 with en_encode held 4 cycles.
        run_encode(16'd11, 23'h0, 4, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("enc11_code", 32'(code), 32'h14);
        chk("enc11_latency", 32'(lat), 32'd23);
        chk("enc11_done_input_cnt", 32'(n_di), 32'd1);
        chk("enc11_done_trans_cnt", 32'(n_dt), 32'd1);
        chk("enc11_receive_busy", 32'(rcv1), 32'h1);
        chk("enc11_receive_end", 32'(rcv_end), 32'h0);
        chk("enc11_out_held", 32'(out_B), 32'h14);

        // Boundary values.
        run_encode(16'd0, 23'h0, 1, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("enc0_code", 32'(code), 32'h0);
        chk("enc0_latency", 32'(lat), 32'd23);
        run_encode(16'd1, 23'h0, 1, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("enc1_code", 32'(code), 32'h1);
        run_encode(16'd5, 23'h0, 1, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("enc5_code", 32'(code), 32'h8);
        chk("enc5_adjacent", 32'(code & (code >> 1)), 32'h0);
        run_encode(16'd65535, 23'h0, 1, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("enc65535_code", 32'(code), 32'h505204);
        chk("enc65535_adjacent", 32'(code & (code >> 1)), 32'h0);
        chk("enc65535_done_trans_cnt", 32'(n_dt), 32'd1);

        // en_encode toggled mid-CALC then held past completion, input changed after capture.
        run_encode(16'd11, 23'h0, 35, 1'b1, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("robust_code", 32'(code), 32'h14);
        chk("robust_latency", 32'(lat), 32'd23);
        chk("robust_done_input_cnt", 32'(n_di), 32'd1);
        chk("robust_done_trans_cnt", 32'(n_dt), 32'd1);
        run_encode(16'd5, 23'h0, 2, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("after_hold_code", 32'(code), 32'h8);
        chk("after_hold_latency", 32'(lat), 32'd23);

        // Reset at the 10th cycle of CALC.
        @(negedge clk);
        input_binary = 16'd65535;
        en_encode = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_B", 32'(out_B), 32'h0);
        chk("midrst_receive", 32'(receive), 32'h0);
        chk("midrst_done_trans", 32'(done_trans), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        en_encode = 1'b0;
        n_dt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_trans) n_dt++;
        end
        chk("midrst_no_done_trans", 32'(n_dt), 32'd0);
        run_encode(16'd11, 23'h0, 4, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("post_rst_code", 32'(code), 32'h14);
        chk("post_rst_latency", 32'(lat), 32'd23);

`ifdef FIB_ZECK_OBFUS_EN
        // Key is flipped by run_encode after capture; result must use the captured key.
        run_encode(16'd11, 23'h7FFFFF, 4, 1'b0, code, lat, n_di, n_dt, rcv1, rcv_end);
        chk("obfus_code", 32'(code), 32'h7FFFEB);
        chk("obfus_latency", 32'(lat), 32'd23);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fib_zeck_encoder_param.md
Name: fib_zeck_encoder_param

Overview:
Parametrised sequential Zeckendorf (Fibonacci binary) encoder, the next generation of the 16-bit encrypt/obfuscate top. Converts an unsigned DATA_W-bit integer into its greedy non-adjacent Fibonacci code, one digit per clock, using an en_encode / done_input / receive / done_trans handshake. Optional keyed XOR obfuscation of the code word. Sits between the binary input stage and the transmit/obfuscation path.

Parameters:
DATA_W, 16, input integer width.
CODE_W, 23, code digits; digit i has weight F(i+2), with F(1)=F(2)=1. Elaboration error unless F(CODE_W+2) > 2^DATA_W-1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
en_encode  input  1  request; level-sampled in IDLE only.
input_binary  input  DATA_W  value to encode; sampled on the capture edge.
done_input  output  1  1-cycle pulse after the capture edge.
receive  output  1  high while the encoder is busy (CALC state).
done_trans  output  1  1-cycle pulse when out_B is updated.
out_B  output  CODE_W  code word; holds until the next done_trans.

Behaviour:
- Reset (rst=0, async): state=IDLE; out_B, done_input, receive and done_trans = 0; internal residual, code register, fa and fb = 0.
- States: IDLE, CALC, HOLD.
- Capture (IDLE with en_encode=1):
  - resid <= input_binary; fa <= F(CODE_W+1); fb <= F(CODE_W); idx <= CODE_W-1.
  - done_input <= 1 and receive <= 1; go to CALC.
- CALC, each edge:
  - bit[idx] <= (resid >= fa).
  - If that bit is 1, resid <= resid - fa.
  - (fa, fb) <= (fb, fa - fb); idx <= idx - 1.
  - done_input is a pulse only, so it returns to 0 after the first CALC edge.
  - fa, fb and resid are DATA_W+1 bits wide and unsigned. Fibonacci weights are generated downward, so there is no ROM.
- Last CALC edge (idx==0):
  - out_B <= final code (XOR key if the optional feature is enabled); done_trans <= 1; receive <= 0.
  - Next state: HOLD if en_encode=1, else IDLE.
- Latency: done_trans is high in the cycle after capture edge + CODE_W edges, i.e. 23 clocks after capture at the defaults.
- done_trans is always a single cycle.
- HOLD: wait for en_encode=0, then go to IDLE. A held en_encode therefore gives exactly one encode, with no retrigger.
- en_encode toggling during CALC is ignored and the operation completes.
- input_binary changes after capture have no effect.
- Greedy output is always Zeckendorf: no two adjacent 1s. Input 0 gives out_B=0 with normal latency.
- Reset mid-CALC aborts immediately: out_B returns to 0 and no done_trans is produced.

Optional Feature:
Macro FIB_ZECK_OBFUS_EN.
- Defined: adds port obfus_key, input, CODE_W bits, sampled on the capture edge. out_B = code XOR latched key.
- Undefined: the port is absent and out_B is the plain code. Timing and handshake are identical in both builds.

Decomposition:
- Package fib_zeck_pkg: state enum {IDLE, CALC, HOLD}; constant function fib(n); constant function for the minimum CODE_W given DATA_W, used by the elaboration check.
- One natural sub-module: fib_weight_gen. It holds the fa/fb down-stepping pair with load/step controls. Everything else stays in one module.

Test Plan:
- Reset: rst low 2 cycles, release, en_encode=0 -> all outputs 0, receive stays 0.
- Encode 11: en_encode held 4 cycles -> done_input pulses once; done_trans once after 23 cycles; out_B=0x000014 (8+3); no second done_trans.
- Boundary values: 0 -> out_B=0; 1 -> 0x000001; 5 -> 0x000008; 65535 -> 0x505204. Each must show no adjacent 1s.
- Handshake robustness: drop and raise en_encode and change input_binary mid-CALC -> result from the original capture; HOLD until en_encode low; next request accepted from IDLE.
- Reset during CALC (cycle 10): outputs cleared at once, no done_trans; a new encode of 11 afterwards gives 0x000014.
- With FIB_ZECK_OBFUS_EN: key 0x7FFFFF, input 11 -> out_B=0x7FFFEB; a key change after capture does not alter the result.
